// File: rtl/add_subt_pkg.sv
// Shared definitions for the pipelined add/sub/accumulate unit.
//   - op encodings carried on the 2-bit op field
//   - saturation mode selectors for the SAT_MODE parameter
package add_subt_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    localparam int SAT_WRAP   = 0;
    localparam int SAT_SIGNED = 1;

endpackage

// File: rtl/add_subt_acc_pipe_if.sv
// Handshake/data bundle for add_subt_acc_pipe.
//   master : drives operands, op, acc_clr, in_valid, out_ready
//   slave  : the arithmetic unit; drives in_ready, out_valid, Res, Out, ovf, acc_q
interface add_subt_acc_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Input_1;
    logic [WIDTH-1:0] Input_2;
    logic [1:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Res;
    logic             Out;
    logic             ovf;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, Input_1, Input_2, op, acc_clr, out_ready,
        input  in_ready, out_valid, Res, Out, ovf, acc_q
    );

    modport slave (
        input  in_valid, Input_1, Input_2, op, acc_clr, out_ready,
        output in_ready, out_valid, Res, Out, ovf, acc_q
    );
endinterface

// File: rtl/add_subt_core.sv
// Combinational add/subtract core: sum = x + (y ^ {sub}) + sub.
//   x, y : operands
//   sub  : 1 selects subtraction
//   sum  : WIDTH-bit result (wrapped)
//   cout : carry-out; for subtraction 1 means no borrow
//   ovf  : signed overflow of the operation
module add_subt_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   full;

    assign y_eff = y ^ {WIDTH{sub}};
    assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    // Same-sign operands producing an opposite-sign result.
    assign ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/add_subt_acc_pipe.sv
// Two-stage pipelined add/sub unit with a running accumulator and optional
// signed saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of add_subt_acc_pipe_if (operands, op, acc_clr,
//                in/out handshakes, Res/Out/ovf result, acc_q)
// The arithmetic happens on the accept edge so the accumulator can be
// written back immediately; stage 1 holds the raw sum/flags, stage 2
// applies the clamp and presents the result.
module add_subt_acc_pipe
    import add_subt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SAT_MODE = SAT_WRAP
) (
    input logic              clk,
    input logic              rst_n,
    add_subt_acc_pipe_if.slave bus
);
    localparam bit SAT_EN = (SAT_MODE == SAT_SIGNED);

    // Clamp value for a signed overflow: negative X overflows downward.
    function automatic logic [WIDTH-1:0] sat_val(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_sum;
    logic             s1_cout;
    logic             s1_ovf;
    logic             s1_xmsb;

    logic             out_valid;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc;

    logic             s2_load;
    logic             in_ready;
    logic             accept;
    logic             is_acc;
    logic             sub;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic             sum_ovf;
    logic [WIDTH-1:0] clamped;

    // in_ready depends only on registered state and out_ready.
    assign s2_load  = !out_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = bus.in_valid && in_ready;

    assign is_acc   = (bus.op == OP_ACC_ADD) || (bus.op == OP_ACC_SUB);
    assign sub      = (bus.op == OP_SUB) || (bus.op == OP_ACC_SUB);
    // A coincident clear takes effect before the accumulate op reads ACC.
    assign acc_base = bus.acc_clr ? '0 : acc;
    assign x        = is_acc ? acc_base : bus.Input_1;
    assign y        = is_acc ? bus.Input_1 : bus.Input_2;

    add_subt_core #(.WIDTH(WIDTH)) u_core (
        .x    (x),
        .y    (y),
        .sub  (sub),
        .sum  (sum),
        .cout (sum_cout),
        .ovf  (sum_ovf)
    );

    assign clamped = (SAT_EN && sum_ovf) ? sat_val(x[WIDTH-1]) : sum;

    // Stage 1: raw result and flags captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_cout  <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_xmsb  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum  <= sum;
                s1_cout <= sum_cout;
                s1_ovf  <= sum_ovf;
                s1_xmsb <= x[WIDTH-1];
            end
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res  <= (SAT_EN && s1_ovf) ? sat_val(s1_xmsb) : s1_sum;
                cout <= s1_cout;
                ovf  <= s1_ovf;
            end
        end
    end

    // Accumulator: written with the clamped result at the accept edge so
    // back-to-back accumulate ops see the updated value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && is_acc) begin
            acc <= clamped;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Res       = res;
    assign bus.Out       = cout;
    assign bus.ovf       = ovf;
    assign bus.acc_q     = acc;
endmodule

// File: tb/tb_add_subt_acc_pipe.sv
// Bench: a wrapping and a saturating instance run the same stimulus; a
// scoreboard per instance is fed from a signed-integer reference model and
// drained by a monitor on the falling edge.
module tb_add_subt_acc_pipe;
    import add_subt_pkg::*;

    localparam int W    = 8;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         acc_clr = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;

    add_subt_acc_pipe_if #(.WIDTH(W)) bw ();
    add_subt_acc_pipe_if #(.WIDTH(W)) bs ();

    add_subt_acc_pipe #(.WIDTH(W), .SAT_MODE(SAT_WRAP)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bw.slave));
    add_subt_acc_pipe #(.WIDTH(W), .SAT_MODE(SAT_SIGNED)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bs.slave));

    assign bw.in_valid = in_valid;  assign bs.in_valid = in_valid;
    assign bw.out_ready = out_ready; assign bs.out_ready = out_ready;
    assign bw.acc_clr = acc_clr;    assign bs.acc_clr = acc_clr;
    assign bw.Input_1 = a;          assign bs.Input_1 = a;
    assign bw.Input_2 = b;          assign bs.Input_2 = b;
    assign bw.op = op;              assign bs.op = op;

    logic         ov[2], ir[2], oc[2], of[2];
    logic [W-1:0] rs[2], aq[2];
    assign ov[0] = bw.out_valid; assign ov[1] = bs.out_valid;
    assign ir[0] = bw.in_ready;  assign ir[1] = bs.in_ready;
    assign oc[0] = bw.Out;       assign oc[1] = bs.Out;
    assign of[0] = bw.ovf;       assign of[1] = bs.ovf;
    assign rs[0] = bw.Res;       assign rs[1] = bs.Res;
    assign aq[0] = bw.acc_q;     assign aq[1] = bs.acc_q;

    exp_t q0[$];
    exp_t q1[$];
    logic [W-1:0] acc_m[2];
    int passed = 0;
    int total  = 0;
    int rmode  = 0;   // 0 ready, 1 pattern 1001, 2 random, 3 stalled
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, got, exp, $time);
    endtask

    // Reference: plain signed/unsigned integer arithmetic.
    function automatic exp_t model(input int sat, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic sub);
        exp_t e;
        int sx, sy, r, ux, uy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        r = sub ? sx - sy : sx + sy;
        e.ovf  = (r > SMAX) || (r < SMIN);
        e.cout = sub ? (ux >= uy) : (ux + uy > (1 << W) - 1);
        if (sat != 0 && r > SMAX) r = SMAX;
        if (sat != 0 && r < SMIN) r = SMIN;
        e.res = r[W-1:0];
        return e;
    endfunction

    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = pat[cyc % 4];
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // Monitor: pops on a handshake, checks hold-stability while stalled and
    // in_ready when both stages are occupied.
    logic         stalled[2] = '{1'b0, 1'b0};
    logic [W-1:0] held_r[2];
    logic         held_c[2], held_o[2];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    exp_t e;
                    int   sz;
                    sz = (i == 0) ? q0.size() : q1.size();
                    if (ov[i]) begin
                        if (stalled[i]) begin
                            chk($sformatf("hold_res%0d", i), 32'(rs[i]), 32'(held_r[i]));
                            chk($sformatf("hold_flags%0d", i), {30'd0, oc[i], of[i]},
                                {30'd0, held_c[i], held_o[i]});
                        end
                        if (!out_ready && sz >= 2)
                            chk($sformatf("in_ready_full%0d", i), 32'(ir[i]), 32'd0);
                        if (out_ready) begin
                            if (sz == 0) begin
                                chk($sformatf("unexpected_out%0d", i), 32'd1, 32'd0);
                            end else begin
                                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                                chk($sformatf("res%0d", i), 32'(rs[i]), 32'(e.res));
                                chk($sformatf("out%0d", i), 32'(oc[i]), 32'(e.cout));
                                chk($sformatf("ovf%0d", i), 32'(of[i]), 32'(e.ovf));
                            end
                        end
                        stalled[i] = !out_ready;
                        held_r[i]  = rs[i];
                        held_c[i]  = oc[i];
                        held_o[i]  = of[i];
                    end else begin
                        stalled[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [1:0] top, input logic tclr);
        int t = 0;
        @(negedge clk);
        a = ta; b = tb_; op = top; acc_clr = tclr; in_valid = 1'b1;
        #1;
        while (!(ir[0] && ir[1]) && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [W-1:0] x, y;
                exp_t e;
                x = top[1] ? (tclr ? '0 : acc_m[i]) : ta;
                y = top[1] ? ta : tb_;
                e = model(i, x, y, top[0]);
                if (i == 0) q0.push_back(e); else q1.push_back(e);
                if (top[1]) acc_m[i] = e.res;
                else if (tclr) acc_m[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        a = 8'hA5; b = 8'h5A;   // junk between transactions
    endtask

    task automatic clr_only();
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        acc_m[0] = '0;
        acc_m[1] = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_acc(input string name);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s%0d", name, i), 32'(aq[i]), 32'(acc_m[i]));
    endtask

    initial begin
        acc_m[0] = '0;
        acc_m[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_res%0d", i), 32'(rs[i]), 32'd0);
            chk($sformatf("rst_flags%0d", i), {30'd0, oc[i], of[i]}, 32'd0);
            chk($sformatf("rst_acc%0d", i), 32'(aq[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, ir[0] & ir[1]}, 32'd1);

        // Basic add and two-cycle latency.
        issue(8'h03, 8'h00, OP_ADD, 1'b0);
        chk("lat_early", 32'(ov[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(ov[0]), 32'd1);
        drain();

        // Reset while a result is in flight.
        rmode = 3;
        issue(8'h11, 8'h22, OP_ADD, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(ov[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {30'd0, ov[0], ov[1]}, 32'd0);
        q0.delete();
        q1.delete();
        acc_m[0] = '0;
        acc_m[1] = '0;
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
        rmode = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Subtract with borrow; signed overflow wrap vs clamp.
        issue(8'h05, 8'h07, OP_SUB, 1'b0);
        issue(8'h7F, 8'h01, OP_ADD, 1'b0);
        issue(8'h80, 8'h01, OP_SUB, 1'b0);
        drain();

        // Accumulate back-to-back, then subtract back to zero.
        clr_only();
        issue(8'h10, 8'h00, OP_ACC_ADD, 1'b0);
        issue(8'h20, 8'h00, OP_ACC_ADD, 1'b0);
        issue(8'h30, 8'h00, OP_ACC_ADD, 1'b0);
        drain();
        chk_acc("acc_60_");
        issue(8'h60, 8'h00, OP_ACC_SUB, 1'b0);
        drain();
        chk_acc("acc_zero_");

        // Streaming with out_ready pattern 1,0,0,1.
        rmode = 1;
        for (int k = 0; k < 8; k++)
            issue(W'($urandom), W'($urandom), 2'($urandom_range(0, 1)), 1'b0);
        drain();
        rmode = 0;

        // Clear coinciding with an accumulate op.
        issue(8'h40, 8'h00, OP_ACC_ADD, 1'b1);
        issue(8'h05, 8'h00, OP_ACC_ADD, 1'b1);
        drain();
        chk_acc("acc_clr_op_");
        // Saturating accumulator at the negative limit.
        issue(8'h80, 8'h00, OP_ACC_ADD, 1'b1);
        issue(8'h01, 8'h00, OP_ACC_SUB, 1'b0);
        drain();
        chk_acc("acc_sat_");

        // Clear during a stall.
        rmode = 3;
        issue(8'h22, 8'h00, OP_ACC_ADD, 1'b0);
        issue(8'h11, 8'h00, OP_ACC_ADD, 1'b0);
        clr_only();
        chk_acc("acc_stall_clr_");
        rmode = 0;
        drain();

        // Randomised traffic with random back-pressure.
        rmode = 2;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) clr_only();
            issue(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0));
        end
        drain();
        rmode = 0;
        drain();
        chk_acc("acc_rand_");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
